// File: rtl/inst_fetch_buf_if.sv
// Fetch buffer bus: instruction-memory request/response channel plus decode-side
// presentation, stall and redirect. The master modport is the fetch buffer side.
interface inst_fetch_buf_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              jump_en_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              hold_flag_i;
    logic              inst_req_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              inst_gnt_i;
    logic              inst_rvalid_i;
    logic [31:0]       inst_rdata_i;
    logic              inst_valid_o;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] if_inst_addr_o;

    modport master (
        input  jump_en_i, jump_addr_i, hold_flag_i,
        input  inst_gnt_i, inst_rvalid_i, inst_rdata_i,
        output inst_req_o, inst_addr_o,
        output inst_valid_o, inst_o, if_inst_addr_o
    );

    modport slave (
        output jump_en_i, jump_addr_i, hold_flag_i,
        output inst_gnt_i, inst_rvalid_i, inst_rdata_i,
        input  inst_req_o, inst_addr_o,
        input  inst_valid_o, inst_o, if_inst_addr_o
    );
endinterface

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: credit-limited sequential fetch into a DEPTH-entry FIFO with
// jump flush and stale-response discard. Define IFB_BYPASS_EN for same-cycle empty bypass.
module inst_fetch_buf #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    inst_fetch_buf_if.master bus
);
    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [ADDR_W-1:0] aq_mem   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  aq_wr_ptr_q, aq_wr_ptr_d, aq_rd_ptr_q, aq_rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic              req, fire, kept, byp, fifo_empty;
    logic              out_valid, pop, fifo_pop, push, aq_push;
    logic [CNT_W:0]    credit_used;
    logic [ADDR_W-1:0] aq_head;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] if_addr;

    // NOTE: every always_comb variable gets a default first so no path can infer a latch.
    always_comb begin
        credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
        fifo_empty  = (count_q == '0);
        aq_head     = aq_mem[aq_rd_ptr_q];

        // FIFO slots plus in-flight requests are the credit pool; never overcommit it.
        req  = !rst && (credit_used < {1'b0, DEPTH_C});
        fire = req && bus.inst_gnt_i;
        kept = bus.inst_rvalid_i && (discard_q == '0) && !bus.jump_en_i;
`ifdef IFB_BYPASS_EN
        byp  = kept && fifo_empty;
`else
        byp  = 1'b0;
`endif
        out_valid = !rst && !bus.jump_en_i && (!fifo_empty || byp);
        inst      = NOP;
        if_addr   = '0;
        if (out_valid) begin
            inst    = fifo_empty ? bus.inst_rdata_i : data_mem[rd_ptr_q];
            if_addr = fifo_empty ? aq_head : addr_mem[rd_ptr_q];
        end

        pop      = out_valid && !bus.hold_flag_i;
        fifo_pop = pop && !fifo_empty;
        push     = kept && !(byp && pop);
        aq_push  = fire && !bus.jump_en_i;

        pc_d          = fire ? pc_q + ADDR_W'(4) : pc_q;
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = fifo_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        aq_wr_ptr_d   = aq_push ? aq_wr_ptr_q + PTR_W'(1) : aq_wr_ptr_q;
        aq_rd_ptr_d   = kept ? aq_rd_ptr_q + PTR_W'(1) : aq_rd_ptr_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
        outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(bus.inst_rvalid_i);
        discard_d     = (bus.inst_rvalid_i && discard_q != '0) ? discard_q - CNT_W'(1) : discard_q;

        // Everything still in flight after this cycle belongs to the old path.
        if (bus.jump_en_i) begin
            pc_d        = bus.jump_addr_i;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            aq_wr_ptr_d = '0;
            aq_rd_ptr_d = '0;
            count_d     = '0;
            discard_d   = outstanding_d;
        end
    end

    assign bus.inst_req_o     = req;
    assign bus.inst_addr_o    = pc_q;
    assign bus.inst_valid_o   = out_valid;
    assign bus.inst_o         = inst;
    assign bus.if_inst_addr_o = if_addr;

    // NOTE: payload storage has no reset; pointers and counts alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.inst_rdata_i;
            addr_mem[wr_ptr_q] <= aq_head;
        end
        if (aq_push) begin
            aq_mem[aq_wr_ptr_q] <= pc_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            aq_wr_ptr_q   <= '0;
            aq_rd_ptr_q   <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            aq_wr_ptr_q   <= aq_wr_ptr_d;
            aq_rd_ptr_q   <= aq_rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end
endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf (default build): stream, stall, jump discard,
// jump/response collision, PC wrap and asynchronous reset with a loaded FIFO.
module tb_inst_fetch_buf;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    inst_fetch_buf_if #(.ADDR_W(32)) bus ();

    inst_fetch_buf #(
        .ADDR_W  (32),
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs and let combinational outputs settle well before posedge.
    task automatic set(input logic jmp, input logic [31:0] jaddr, input logic hold,
                       input logic gnt, input logic rv, input logic [31:0] rd);
        bus.jump_en_i     = jmp;
        bus.jump_addr_i   = jaddr;
        bus.hold_flag_i   = hold;
        bus.inst_gnt_i    = gnt;
        bus.inst_rvalid_i = rv;
        bus.inst_rdata_i  = rd;
        #1;
    endtask

    task automatic step(input logic jmp, input logic [31:0] jaddr, input logic hold,
                        input logic gnt, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        set(jmp, jaddr, hold, gnt, rv, rd);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", bus.inst_req_o, 32'h0);
        check("rst_valid", bus.inst_valid_o, 32'h0);
        check("rst_inst", bus.inst_o, 32'h0000_0013);
        check("rst_ifaddr", bus.if_inst_addr_o, 32'h0);

        // Streaming: grant always, response one cycle after grant.
        @(negedge clk);
        rst = 1'b0;
        set(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("boot_req", bus.inst_req_o, 32'h1);
        check("boot_addr", bus.inst_addr_o, 32'h0);
        check("boot_valid", bus.inst_valid_o, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0000);
        check("c1_addr", bus.inst_addr_o, 32'h4);
        check("c1_valid_registered", bus.inst_valid_o, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0004);
        check("c2_valid", bus.inst_valid_o, 32'h1);
        check("c2_inst", bus.inst_o, 32'hA5A5_0000);
        check("c2_ifaddr", bus.if_inst_addr_o, 32'h0);
        check("c2_addr", bus.inst_addr_o, 32'h8);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0008);
        check("c3_inst", bus.inst_o, 32'hA5A5_0004);
        check("c3_ifaddr", bus.if_inst_addr_o, 32'h4);
        check("c3_addr", bus.inst_addr_o, 32'hC);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA5A5_000C);
        check("c4_inst", bus.inst_o, 32'hA5A5_0008);
        check("c4_ifaddr", bus.if_inst_addr_o, 32'h8);

        // Stall for 10 cycles: FIFO fills to 4 and fetch stops.
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0010);
        check("h0_inst", bus.inst_o, 32'hA5A5_000C);
        check("h0_ifaddr", bus.if_inst_addr_o, 32'hC);
        check("h0_req", bus.inst_req_o, 32'h1);
        check("h0_addr", bus.inst_addr_o, 32'h14);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0014);
        check("h1_req", bus.inst_req_o, 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0018);
        check("h2_req_drop", bus.inst_req_o, 32'h0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        end
        check("h9_req", bus.inst_req_o, 32'h0);
        check("h9_valid", bus.inst_valid_o, 32'h1);
        check("h9_inst_stable", bus.inst_o, 32'hA5A5_000C);
        check("h9_ifaddr_stable", bus.if_inst_addr_o, 32'hC);
        check("h9_addr", bus.inst_addr_o, 32'h1C);

        // Release: drain in order, fetch resumes.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("d0_inst", bus.inst_o, 32'hA5A5_000C);
        check("d0_req_full", bus.inst_req_o, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("d1_inst", bus.inst_o, 32'hA5A5_0010);
        check("d1_ifaddr", bus.if_inst_addr_o, 32'h10);
        check("d1_req", bus.inst_req_o, 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA5A5_001C);
        check("d2_inst", bus.inst_o, 32'hA5A5_0014);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("d3_inst", bus.inst_o, 32'hA5A5_0018);
        check("d3_addr", bus.inst_addr_o, 32'h24);

        // Jump to 0x100 with two requests (0x20, 0x24) outstanding.
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        check("j_flush_valid", bus.inst_valid_o, 32'h0);
        check("j_flush_inst", bus.inst_o, 32'h0000_0013);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0020);
        check("j1_valid", bus.inst_valid_o, 32'h0);
        check("j1_addr", bus.inst_addr_o, 32'h100);
        check("j1_req", bus.inst_req_o, 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0024);
        check("j2_valid", bus.inst_valid_o, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0100);
        check("j3_valid", bus.inst_valid_o, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("j4_valid", bus.inst_valid_o, 32'h1);
        check("j4_ifaddr", bus.if_inst_addr_o, 32'h100);
        check("j4_inst", bus.inst_o, 32'hA5A5_0100);

        // Jump coincident with a response and a grant: both old items dropped.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("k0_addr", bus.inst_addr_o, 32'h104);
        check("k0_valid", bus.inst_valid_o, 32'h0);
        step(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'hA5A5_0104);
        check("k1_req", bus.inst_req_o, 32'h1);
        check("k1_addr", bus.inst_addr_o, 32'h108);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0108);
        check("k2_valid_empty", bus.inst_valid_o, 32'h0);
        check("k2_inst", bus.inst_o, 32'h0000_0013);
        check("k2_addr", bus.inst_addr_o, 32'h200);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("k3_valid_dropped", bus.inst_valid_o, 32'h0);
        check("k3_req", bus.inst_req_o, 32'h1);

        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("w0_addr", bus.inst_addr_o, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h5A5A_FFFC);
        check("w1_addr_wrap", bus.inst_addr_o, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("w2_valid", bus.inst_valid_o, 32'h1);
        check("w2_inst", bus.inst_o, 32'h5A5A_FFFC);
        check("w2_ifaddr", bus.if_inst_addr_o, 32'hFFFF_FFFC);
        check("w2_addr_stable", bus.inst_addr_o, 32'h0);

        // Load three entries under stall, then reset asynchronously between edges.
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("r0_addr", bus.inst_addr_o, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0000);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0004);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA5A5_0008);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("r4_valid", bus.inst_valid_o, 32'h1);
        check("r4_inst", bus.inst_o, 32'hA5A5_0000);
        check("r4_addr", bus.inst_addr_o, 32'hC);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", bus.inst_valid_o, 32'h0);
        check("arst_inst", bus.inst_o, 32'h0000_0013);
        check("arst_ifaddr", bus.if_inst_addr_o, 32'h0);
        check("arst_req", bus.inst_req_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("post_rst_req", bus.inst_req_o, 32'h1);
        check("post_rst_addr", bus.inst_addr_o, 32'h0);
        check("post_rst_valid", bus.inst_valid_o, 32'h0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
